// File: rtl/tile_map_ctrl_pkg.sv
// Shared constants and state types for the tile map controller.
package tile_map_ctrl_pkg;

    localparam int TILE_ADDR_W   = 12;
    localparam int TILE_DATA_W   = 6;
    localparam int TILE_MAP_SIZE = 4000;

    typedef enum logic [1:0] {
        CPU_IDLE    = 2'd0,
        CPU_RD_WAIT = 2'd1,
        CPU_ACK     = 2'd2
    } cpu_state_t;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/tile_map_ctrl_if.sv
// CPU iomem bus: request held until a single-cycle ready pulse.
interface tile_map_ctrl_if
    import tile_map_ctrl_pkg::*;
#(
    parameter int ADDR_W = TILE_ADDR_W,
    parameter int DATA_W = TILE_DATA_W
);
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata
    );
endinterface

// File: rtl/tile_fill_engine.sv
// Hardware fill engine: writes one latched tile value to map entries 0..MAP_SIZE-1.
module tile_fill_engine
    import tile_map_ctrl_pkg::*;
#(
    parameter int ADDR_W   = TILE_ADDR_W,
    parameter int DATA_W   = TILE_DATA_W,
    parameter int MAP_SIZE = TILE_MAP_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAP_SIZE - 1);

    fill_state_t       state;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] latch;

    // Fill sequencer: start latches the value, then one write per cycle up to LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL_IDLE;
            busy  <= 1'b0;
            count <= '0;
            latch <= '0;
        end else begin
            case (state)
                FILL_IDLE: begin
                    if (start) begin
                        latch <= value;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= FILL_RUN;
                    end
                end
                FILL_RUN: begin
                    if (count == LAST) begin
                        busy  <= 1'b0;
                        state <= FILL_IDLE;
                    end else begin
                        count <= count + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign wen   = busy;
    assign waddr = count;
    assign wdata = latch;

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map arbiter: video reads first, CPU second on the read port;
// fill engine first, CPU second on the write port.
module tile_map_ctrl
    import tile_map_ctrl_pkg::*;
#(
    parameter int ADDR_W   = TILE_ADDR_W,
    parameter int DATA_W   = TILE_DATA_W,
    parameter int MAP_SIZE = TILE_MAP_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic                  vid_valid,
    output logic [DATA_W-1:0]     vid_data,
    tile_map_ctrl_if.slave        cpu,
    input  logic                  fill_start,
    input  logic [DATA_W-1:0]     fill_value,
    output logic                  fill_busy,
    output logic                  mem_ren,
    output logic [ADDR_W-1:0]     mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata
);
    cpu_state_t        state;
    logic              cpu_rd_issue;
    logic              cpu_wr_issue;
    logic              fill_wen;
    logic [ADDR_W-1:0] fill_waddr;
    logic [DATA_W-1:0] fill_wdata;

    tile_fill_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAP_SIZE (MAP_SIZE)
    ) u_fill (
        .clk   (clk),
        .reset (reset),
        .start (fill_start),
        .value (fill_value),
        .busy  (fill_busy),
        .wen   (fill_wen),
        .waddr (fill_waddr),
        .wdata (fill_wdata)
    );

    // CPU grant: reads yield to video, writes yield to a running or starting fill.
    always_comb begin
        cpu_rd_issue = 1'b0;
        cpu_wr_issue = 1'b0;
        if (!reset && state == CPU_IDLE && cpu.cpu_valid) begin
            if (cpu.cpu_we) begin
                cpu_wr_issue = !fill_busy && !fill_start;
            end else begin
                cpu_rd_issue = !vid_req;
            end
        end
    end

    // Read port mux.
    always_comb begin
        mem_ren   = 1'b0;
        mem_raddr = '0;
        if (!reset && vid_req) begin
            mem_ren   = 1'b1;
            mem_raddr = vid_addr;
        end else if (cpu_rd_issue) begin
            mem_ren   = 1'b1;
            mem_raddr = cpu.cpu_addr;
        end
    end

    // Write port mux; the two sources are mutually exclusive by the grant above.
    always_comb begin
        mem_wen   = fill_wen | cpu_wr_issue;
        mem_waddr = '0;
        mem_wdata = '0;
        if (fill_wen) begin
            mem_waddr = fill_waddr;
            mem_wdata = fill_wdata;
        end else if (cpu_wr_issue) begin
            mem_waddr = cpu.cpu_addr;
            mem_wdata = cpu.cpu_wdata;
        end
    end

    // Video data qualifier follows the RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= vid_req;
        end
    end

    assign vid_data = mem_rdata;

    // CPU access sequencer with registered ready pulse and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= CPU_IDLE;
            cpu.cpu_ready <= 1'b0;
            cpu.cpu_rdata <= '0;
        end else begin
            cpu.cpu_ready <= 1'b0;
            case (state)
                CPU_IDLE: begin
                    if (cpu_rd_issue) begin
                        state <= CPU_RD_WAIT;
                    end else if (cpu_wr_issue) begin
                        state         <= CPU_ACK;
                        cpu.cpu_ready <= 1'b1;
                    end
                end
                CPU_RD_WAIT: begin
                    cpu.cpu_rdata <= mem_rdata;
                    cpu.cpu_ready <= 1'b1;
                    state         <= CPU_ACK;
                end
                CPU_ACK: begin
                    state <= CPU_IDLE;
                end
                default: begin
                    state <= CPU_IDLE;
                end
            endcase
        end
    end

endmodule
